// File: rtl/vscale_htif_pcr_responder.sv
// HTIF PCR target-side responder.
// Owns the tohost/fromhost registers, answers one host PCR read/write per
// handshake with exactly one response, and lets the core CSR file write
// tohost and clear fromhost without ever being stalled by host traffic.
module vscale_htif_pcr_responder #(
  parameter int unsigned PCR_WIDTH      = 64,
  parameter logic [11:0] ADDR_TO_HOST   = 12'h780,
  parameter logic [11:0] ADDR_FROM_HOST = 12'h781,
  parameter bit          CLEAR_ON_READ  = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 htif_pcr_req_valid,
  output logic                 htif_pcr_req_ready,
  input  logic                 htif_pcr_req_rw,
  input  logic [11:0]          htif_pcr_req_addr,
  input  logic [PCR_WIDTH-1:0] htif_pcr_req_data,
  output logic                 htif_pcr_resp_valid,
  input  logic                 htif_pcr_resp_ready,
  output logic [PCR_WIDTH-1:0] htif_pcr_resp_data,
  input  logic                 core_tohost_we,
  input  logic [PCR_WIDTH-1:0] core_tohost_wdata,
  input  logic                 core_fromhost_clr,
  output logic [PCR_WIDTH-1:0] tohost,
  output logic [PCR_WIDTH-1:0] fromhost
);

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

  state_e               state_q;
  logic [PCR_WIDTH-1:0] resp_data_q;
  logic [PCR_WIDTH-1:0] tohost_q;
  logic [PCR_WIDTH-1:0] tohost_d;
  logic [PCR_WIDTH-1:0] fromhost_q;
  logic [PCR_WIDTH-1:0] fromhost_d;
  logic [PCR_WIDTH-1:0] rdata;
  logic                 req_ready;
  logic                 accept;
  logic                 hit_to;
  logic                 hit_from;

  // Handshake, address decode, old-value lookup and register next-state.
  always_comb begin
    hit_to    = (htif_pcr_req_addr == ADDR_TO_HOST);
    hit_from  = (htif_pcr_req_addr == ADDR_FROM_HOST);
    // A response being consumed this cycle frees the slot for a new request.
    req_ready = (state_q == IDLE) || htif_pcr_resp_ready;
    accept    = htif_pcr_req_valid && req_ready;

    // Reads and writes both return the pre-update value (swap semantics);
    // unmapped addresses return zero.
    rdata = '0;
    if (hit_to) begin
      rdata = tohost_q;
    end else if (hit_from) begin
      rdata = fromhost_q;
    end

    // Core write is applied last so it overrides host write/read-clear;
    // the host still receives the old value through rdata.
    tohost_d = tohost_q;
    if (accept && hit_to) begin
      if (htif_pcr_req_rw) begin
        tohost_d = htif_pcr_req_data;
      end else if (CLEAR_ON_READ) begin
        tohost_d = '0;
      end
    end
    if (core_tohost_we) begin
      tohost_d = core_tohost_wdata;
    end

    // Host write is applied last so it overrides a same-cycle core clear.
    fromhost_d = fromhost_q;
    if (core_fromhost_clr) begin
      fromhost_d = '0;
    end
    if (accept && hit_from && htif_pcr_req_rw) begin
      fromhost_d = htif_pcr_req_data;
    end
  end

  // Response FSM with registered valid/data; reset drops any pending response.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      resp_data_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q     <= RESP;
            resp_data_q <= rdata;
          end
        end
        RESP: begin
          if (accept) begin
            state_q     <= RESP;
            resp_data_q <= rdata;
          end else if (htif_pcr_resp_ready) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // tohost/fromhost storage.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tohost_q   <= '0;
      fromhost_q <= '0;
    end else begin
      tohost_q   <= tohost_d;
      fromhost_q <= fromhost_d;
    end
  end

  assign htif_pcr_req_ready  = req_ready;
  assign htif_pcr_resp_valid = (state_q == RESP);
  assign htif_pcr_resp_data  = resp_data_q;
  assign tohost              = tohost_q;
  assign fromhost            = fromhost_q;

endmodule

// File: tb/tb_vscale_htif_pcr_responder.sv
// Bench for the HTIF PCR responder: directed vector table, a hand-written
// swap/collision sequence, then randomized traffic against a queue model.
module tb_vscale_htif_pcr_responder;

  localparam int unsigned W = 64;
  localparam logic [11:0] A_TO   = 12'h780;
  localparam logic [11:0] A_FROM = 12'h781;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid;
  logic         req_ready;
  logic         req_rw;
  logic [11:0]  req_addr;
  logic [W-1:0] req_data;
  logic         resp_valid;
  logic         resp_ready;
  logic [W-1:0] resp_data;
  logic         core_we;
  logic [W-1:0] core_wdata;
  logic         core_clr;
  logic [W-1:0] tohost;
  logic [W-1:0] fromhost;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vscale_htif_pcr_responder #(
    .PCR_WIDTH     (W),
    .ADDR_TO_HOST  (A_TO),
    .ADDR_FROM_HOST(A_FROM),
    .CLEAR_ON_READ (1'b1)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .htif_pcr_req_valid (req_valid),
    .htif_pcr_req_ready (req_ready),
    .htif_pcr_req_rw    (req_rw),
    .htif_pcr_req_addr  (req_addr),
    .htif_pcr_req_data  (req_data),
    .htif_pcr_resp_valid(resp_valid),
    .htif_pcr_resp_ready(resp_ready),
    .htif_pcr_resp_data (resp_data),
    .core_tohost_we     (core_we),
    .core_tohost_wdata  (core_wdata),
    .core_fromhost_clr  (core_clr),
    .tohost             (tohost),
    .fromhost           (fromhost)
  );

  typedef struct {
    bit           rstn, v, rw;
    logic [11:0]  a;
    logic [W-1:0] d;
    bit           rr, cwe;
    logic [W-1:0] cwd;
    bit           cclr;
    bit           chk, e_rdy, e_rv;
    logic [W-1:0] e_rd;
    bit           dchk;
    logic [W-1:0] e_to, e_fr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit rstn, bit v, bit rw, logic [11:0] a, logic [W-1:0] d,
                              bit rr, bit cwe, logic [W-1:0] cwd, bit cclr,
                              bit chk, bit e_rdy, bit e_rv, logic [W-1:0] e_rd, bit dchk,
                              logic [W-1:0] e_to, logic [W-1:0] e_fr);
    vec_t r;
    r.rstn = rstn; r.v = v; r.rw = rw; r.a = a; r.d = d;
    r.rr = rr; r.cwe = cwe; r.cwd = cwd; r.cclr = cclr;
    r.chk = chk; r.e_rdy = e_rdy; r.e_rv = e_rv; r.e_rd = e_rd; r.dchk = dchk;
    r.e_to = e_to; r.e_fr = e_fr;
    return r;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit rstn, input bit v, input bit rw, input logic [11:0] a,
                       input logic [W-1:0] d, input bit rr, input bit cwe,
                       input logic [W-1:0] cwd, input bit cclr);
    reset = rstn; req_valid = v; req_rw = rw; req_addr = a; req_data = d;
    resp_ready = rr; core_we = cwe; core_wdata = cwd; core_fromhost_clr_set(cclr);
  endtask

  task automatic core_fromhost_clr_set(input bit c);
    core_clr = c;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model state: pending responses as a queue, registers as values.
  logic [W-1:0] rq[$];
  logic [W-1:0] m_to, m_fr;

  task automatic model_step();
    bit           rdy, acc;
    logic [W-1:0] old, nto, nfr;
    if (!reset) begin
      rq.delete();
      m_to = '0;
      m_fr = '0;
    end else begin
      rdy = (rq.size() == 0) || resp_ready;
      acc = req_valid && rdy;
      if (rq.size() != 0 && resp_ready) void'(rq.pop_front());
      old = (req_addr == A_TO) ? m_to : (req_addr == A_FROM) ? m_fr : '0;
      nto = m_to;
      nfr = m_fr;
      if (acc) begin
        rq.push_back(old);
        if (req_addr == A_TO) nto = req_rw ? req_data : '0;
        if (req_addr == A_FROM && req_rw) nfr = req_data;
      end
      if (core_we) nto = core_wdata;
      if (core_clr && !(acc && req_rw && req_addr == A_FROM)) nfr = '0;
      m_to = nto;
      m_fr = nfr;
    end
  endtask

  initial begin
    vec_t r;
    bit   exp_rdy;

    // Directed table: inputs held for one cycle, expectations are the
    // outputs observed during that cycle (before its rising edge).
    tbl.push_back(mk(0,1,0,A_TO,0,1,0,0,0,   0,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,0,A_TO,0,1,0,0,0,   1,1,0,0,1,0,0));
    tbl.push_back(mk(0,1,0,A_TO,0,1,0,0,0,   1,1,0,0,1,0,0));
    tbl.push_back(mk(1,1,0,A_TO,0,1,0,0,0,   1,1,0,0,1,0,0));
    tbl.push_back(mk(1,0,0,A_TO,0,1,0,0,0,   1,1,1,0,0,0,0));
    tbl.push_back(mk(1,1,0,A_TO,0,1,1,1,0,   1,1,0,0,0,0,0));
    tbl.push_back(mk(1,1,0,A_TO,0,1,0,0,0,   1,1,1,0,0,1,0));
    tbl.push_back(mk(1,1,0,A_TO,0,1,0,0,0,   1,1,1,1,0,0,0));
    tbl.push_back(mk(1,0,0,A_TO,0,1,0,0,0,   1,1,1,0,0,0,0));
    tbl.push_back(mk(1,0,0,A_TO,0,1,1,64'h2A,0, 1,1,0,0,0,0,0));
    tbl.push_back(mk(1,1,0,A_TO,0,1,0,0,0,   1,1,0,0,0,64'h2A,0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(1,1,0,A_TO,0,0,0,0,0, 1,0,1,64'h2A,0,0,0));
    tbl.push_back(mk(1,1,0,A_TO,0,1,0,0,0,   1,1,1,64'h2A,0,0,0));
    tbl.push_back(mk(1,0,0,A_TO,0,1,0,0,0,   1,1,1,0,0,0,0));
    tbl.push_back(mk(1,1,1,A_FROM,64'h55,1,0,0,0, 1,1,0,0,0,0,0));
    tbl.push_back(mk(1,1,1,A_FROM,64'h77,1,0,0,1, 1,1,1,0,0,0,64'h55));
    tbl.push_back(mk(1,0,0,A_FROM,0,1,0,0,1, 1,1,1,64'h55,0,0,64'h77));
    tbl.push_back(mk(1,0,0,A_TO,0,1,1,64'h3,0, 1,1,0,0,0,0,0));
    tbl.push_back(mk(1,1,0,A_TO,0,1,1,64'h9,0, 1,1,0,0,0,64'h3,0));
    tbl.push_back(mk(1,0,0,A_TO,0,1,0,0,0,   1,1,1,64'h3,0,64'h9,0));
    tbl.push_back(mk(1,1,1,12'h123,64'hFF,1,0,0,0, 1,1,0,0,0,64'h9,0));
    tbl.push_back(mk(1,1,0,12'h123,0,1,0,0,0, 1,1,1,0,0,64'h9,0));
    tbl.push_back(mk(1,0,0,12'h123,0,1,0,0,0, 1,1,1,0,0,64'h9,0));
    tbl.push_back(mk(1,1,0,A_TO,0,0,0,0,0,   1,1,0,0,0,64'h9,0));
    tbl.push_back(mk(0,0,0,A_TO,0,0,0,0,0,   1,0,1,64'h9,0,0,0));
    tbl.push_back(mk(1,0,0,A_TO,0,0,0,0,0,   1,1,0,0,1,0,0));
    tbl.push_back(mk(1,0,0,A_TO,0,1,0,0,0,   1,1,0,0,1,0,0));
    tbl.push_back(mk(1,0,0,A_TO,0,1,0,0,0,   1,1,0,0,1,0,0));

    foreach (tbl[i]) begin
      r = tbl[i];
      drive(r.rstn, r.v, r.rw, r.a, r.d, r.rr, r.cwe, r.cwd, r.cclr);
      #1;
      if (r.chk) begin
        chk($sformatf("tbl%0d_req_ready", i), {63'b0, req_ready}, {63'b0, r.e_rdy});
        chk($sformatf("tbl%0d_resp_valid", i), {63'b0, resp_valid}, {63'b0, r.e_rv});
        if (r.e_rv || r.dchk) chk($sformatf("tbl%0d_resp_data", i), resp_data, r.e_rd);
        chk($sformatf("tbl%0d_tohost", i), tohost, r.e_to);
        chk($sformatf("tbl%0d_fromhost", i), fromhost, r.e_fr);
      end
      tick();
    end

    // Host swap-write of tohost colliding with a core write, then a plain swap.
    drive(1,1,1,A_TO,64'hAB,1,1,64'hCD,0);
    tick();
    drive(1,1,1,A_TO,64'h11,1,0,0,0);
    #1;
    chk("swap1_valid", {63'b0, resp_valid}, 64'd1);
    chk("swap1_data", resp_data, 64'h0);
    chk("swap1_tohost", tohost, 64'hCD);
    tick();
    drive(1,0,0,A_TO,0,1,0,0,0);
    #1;
    chk("swap2_valid", {63'b0, resp_valid}, 64'd1);
    chk("swap2_data", resp_data, 64'hCD);
    chk("swap2_tohost", tohost, 64'h11);
    tick();
    #1;
    chk("swap3_valid", {63'b0, resp_valid}, 64'd0);

    // Randomized traffic against the queue model.
    rq.delete();
    m_to = 64'h11;
    m_fr = '0;
    for (int n = 0; n < 800; n++) begin
      int unsigned sel;
      logic [11:0] a;
      sel = $urandom_range(0, 3);
      a = (sel == 1) ? A_FROM : (sel == 2) ? 12'($urandom) : A_TO;
      drive($urandom_range(0, 49) != 0, $urandom_range(0, 2) != 0, 1'($urandom), a,
            {$urandom, $urandom}, $urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0,
            {$urandom, $urandom}, $urandom_range(0, 5) == 0);
      #1;
      exp_rdy = (rq.size() == 0) || resp_ready;
      chk("rnd_req_ready", {63'b0, req_ready}, {63'b0, exp_rdy});
      chk("rnd_resp_valid", {63'b0, resp_valid}, {63'b0, rq.size() != 0});
      if (rq.size() != 0) chk("rnd_resp_data", resp_data, rq[0]);
      chk("rnd_tohost", tohost, m_to);
      chk("rnd_fromhost", fromhost, m_fr);
      model_step();
      if (rq.size() > 1) chk("rnd_outstanding", 64'(rq.size()), 64'd1);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vscale_htif_pcr_responder.md
Name: vscale_htif_pcr_responder

Overview:
Target-side responder for the HTIF PCR request/response interface; the host testbench and HTIF bridge are the initiators. Owns the tohost and fromhost registers. Accepts one host PCR read or write per handshake and returns exactly one response per accepted request. Exposes both registers to the core CSR file through a simple write/clear port.

Parameters:
PCR_WIDTH, 64, width of PCR data and tohost/fromhost registers
ADDR_TO_HOST, 12'h780, PCR address decoded as tohost
ADDR_FROM_HOST, 12'h781, PCR address decoded as fromhost
CLEAR_ON_READ, 1, when 1 an accepted host read of tohost clears tohost

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-low reset
htif_pcr_req_valid  input  1  host request valid
htif_pcr_req_ready  output  1  responder can accept a request this cycle
htif_pcr_req_rw  input  1  1 = write, 0 = read
htif_pcr_req_addr  input  12  PCR address
htif_pcr_req_data  input  PCR_WIDTH  write data
htif_pcr_resp_valid  output  1  response valid
htif_pcr_resp_ready  input  1  host accepts the response
htif_pcr_resp_data  output  PCR_WIDTH  response data
core_tohost_we  input  1  core writes tohost
core_tohost_wdata  input  PCR_WIDTH  core tohost data
core_fromhost_clr  input  1  core clears fromhost
tohost  output  PCR_WIDTH  current tohost value
fromhost  output  PCR_WIDTH  current fromhost value

Behaviour:
- Reset: clock clk; reset is synchronous and active-low. While reset==0, state = IDLE, resp_valid = 0, resp_data = 0, tohost = 0, fromhost = 0. Reset asserted mid-transaction drops any pending response; it is never replayed.
- States:
  - IDLE: no response is pending.
  - RESP: resp_valid = 1.
- Ready: req_ready = (state==IDLE) || (resp_valid && resp_ready). This is combinational and gives full throughput of 1 request per cycle.
- Accept: a request is accepted when req_valid && req_ready. The next state is RESP, and resp_valid rises the cycle after acceptance (latency 1).
- Leaving RESP: the response is consumed when resp_valid && resp_ready. If no new request is accepted in that cycle, the next state is IDLE.
- Holding: while resp_valid && !resp_ready, resp_data and resp_valid hold stable and req_ready = 0.
- Response data:
  - Read: value of the addressed register as sampled in the accept cycle, before any update in that cycle.
  - Write: previous value of the addressed register (swap semantics).
  - Unmapped address: read returns 0; write is ignored and returns 0. A response is still always generated.
- Host write effects (applied at the clock edge of the accept cycle): write to ADDR_FROM_HOST sets fromhost = req_data; write to ADDR_TO_HOST sets tohost = req_data.
- Host read of tohost with CLEAR_ON_READ = 1: tohost <= 0 at the accept edge.
- Simultaneous events, tohost:
  - core_tohost_we in the same cycle as a host tohost read-clear or host tohost write: the core write wins and tohost = core_tohost_wdata. The host response carries the old value, so no core value is lost.
- Simultaneous events, fromhost:
  - core_fromhost_clr in the same cycle as a host fromhost write: the host write wins.
  - core_fromhost_clr alone: fromhost <= 0.
- Core writes are never stalled by host traffic.
- Outputs tohost and fromhost are registered values; an update is visible the cycle after the edge that performed it.
- The block never issues a response without a prior accepted request. There is never more than 1 outstanding response.

Test Plan:
- Reset/idle: hold reset=0 for 3 cycles with req_valid=1 -> resp_valid=0, req_ready=1 (IDLE), tohost=fromhost=0. Release reset -> first read of 0x780 returns 0 one cycle after accept.
- Core-to-host pass flag:
  - Stimulus: core_tohost_we with data 1, then host polls 0x780 with req_valid held high and resp_ready=1.
  - Required: back-to-back responses 0,…,1 at one per cycle, then 0 after the read-clear.
  - Required: tohost=0 on the cycle after the accepting read.
- Backpressure: resp_ready=0 for 4 cycles after a read of tohost=0x2A -> resp_data stays 0x2A and resp_valid stays 1, req_ready=0, no second accept. Then resp_ready=1 -> a new request is accepted in that same cycle.
- Fromhost write/clear:
  - Host write 0x781 with data 0x55 -> response 0 (old value), fromhost=0x55 the next cycle.
  - Host write 0x781 with data 0x77 in the same cycle as core_fromhost_clr -> fromhost=0x77.
- Collision on tohost: host read of 0x780 (tohost=0x3) in the same cycle as core_tohost_we with data 0x9 -> response 0x3, tohost=0x9 (not cleared).
- Unmapped address and mid-transaction reset:
  - Write 0x123 with data 0xFF -> response 0, registers unchanged.
  - Assert reset while resp_valid=1 -> resp_valid=0 on the next cycle, no late response after release.
